// File: rtl/snake_pkg.sv
// Shared snake-game definitions: playfield geometry, segment memory sizing,
// coordinate type and the detector state encoding reused by neighbouring blocks.
package snake_pkg;

  localparam int GRID_W  = 32;
  localparam int GRID_H  = 24;
  localparam int COORD_W = 6;
  localparam int MAX_LEN = 64;
  localparam int IDX_W   = 6;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [IDX_W:0]     len_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WALL = 2'b01,
    SCAN = 2'b10
  } state_t;

  // A zero length still means the head exists; lengths past the RAM depth saturate.
  function automatic len_t clamp_len(input len_t raw);
    if (raw == '0) return len_t'(1);
    if (raw > len_t'(MAX_LEN)) return len_t'(MAX_LEN);
    return raw;
  endfunction

endpackage

// File: rtl/collision_detector.sv
// Per-move collision check: wall test on the latched head, then a pipelined
// scan of body segments 1..len-1 read from the one-cycle-latency segment RAM.
module collision_detector
  import snake_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             moveTick,
  input  coord_t           headX,
  input  coord_t           headY,
  input  len_t             snakeLength,
  output logic [IDX_W-1:0] segAddr,
  input  coord_t           segX,
  input  coord_t           segY,
  output logic             busy,
  output logic             checkDone,
  output logic             collision,
  output logic             tickOverrun
);

  localparam coord_t X_LIMIT = coord_t'(GRID_W);
  localparam coord_t Y_LIMIT = coord_t'(GRID_H);
  localparam len_t   LEN_ONE = len_t'(1);

  state_t           state_reg;
  coord_t           head_x_reg;
  coord_t           head_y_reg;
  len_t             len_reg;
  logic [IDX_W-1:0] seg_addr_reg;
  logic [IDX_W-1:0] data_idx_reg;
  logic             valid_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             collision_reg;
  logic             overrun_reg;

  logic [IDX_W-1:0] last_idx;
  logic             wall_hit;
  logic             seg_hit;

  // len is 1..MAX_LEN, so the low bits minus one wrap correctly to MAX_LEN-1.
  assign last_idx = len_reg[IDX_W-1:0] - IDX_W'(1);
  assign wall_hit = (head_x_reg >= X_LIMIT) || (head_y_reg >= Y_LIMIT);
  assign seg_hit  = (segX == head_x_reg) && (segY == head_y_reg);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      head_x_reg    <= '0;
      head_y_reg    <= '0;
      len_reg       <= '0;
      seg_addr_reg  <= '0;
      data_idx_reg  <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      collision_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          seg_addr_reg <= '0;
          valid_reg    <= 1'b0;
          if (moveTick) begin
            head_x_reg <= headX;
            head_y_reg <= headY;
            len_reg    <= clamp_len(snakeLength);
            busy_reg   <= 1'b1;
            state_reg  <= WALL;
          end
        end

        WALL: begin
          if (moveTick) overrun_reg <= 1'b1;
          if (wall_hit) begin
            collision_reg <= 1'b1;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end else if (len_reg <= LEN_ONE) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            seg_addr_reg <= IDX_W'(1);
            valid_reg    <= 1'b0;
            state_reg    <= SCAN;
          end
        end

        SCAN: begin
          if (moveTick) overrun_reg <= 1'b1;
          // RAM data always trails the address by one cycle; the first data
          // word after entry belongs to the pre-scan address and is ignored.
          valid_reg    <= 1'b1;
          data_idx_reg <= seg_addr_reg;
          if (seg_addr_reg != last_idx) seg_addr_reg <= seg_addr_reg + 1'b1;
          if (valid_reg && seg_hit) begin
            collision_reg <= 1'b1;
            done_reg      <= 1'b1;
            busy_reg      <= 1'b0;
            seg_addr_reg  <= '0;
            valid_reg     <= 1'b0;
            state_reg     <= IDLE;
          end else if (valid_reg && (data_idx_reg == last_idx)) begin
            done_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            seg_addr_reg <= '0;
            valid_reg    <= 1'b0;
            state_reg    <= IDLE;
          end
        end

        default: begin
          busy_reg     <= 1'b0;
          seg_addr_reg <= '0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign segAddr     = seg_addr_reg;
  assign busy        = busy_reg;
  assign checkDone   = done_reg;
  assign collision   = collision_reg;
  assign tickOverrun = overrun_reg;

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: constant vector table, hand-written
// corner sequences and random moves scored by a per-move timing/outcome model.
module tb_collision_detector;

  logic       clock;
  logic       reset;
  logic       move_tick;
  logic [5:0] head_x;
  logic [5:0] head_y;
  logic [6:0] snake_length;
  logic [5:0] seg_addr;
  logic [5:0] seg_x;
  logic [5:0] seg_y;
  logic       busy;
  logic       check_done;
  logic       collision;
  logic       tick_overrun;

  logic [5:0] ram_x [64];
  logic [5:0] ram_y [64];

  int checks = 0;
  int errors = 0;
  int coll_model = 0;
  int addr_log[$];

  collision_detector dut (
    .clock       (clock),
    .reset       (reset),
    .moveTick    (move_tick),
    .headX       (head_x),
    .headY       (head_y),
    .snakeLength (snake_length),
    .segAddr     (seg_addr),
    .segX        (seg_x),
    .segY        (seg_y),
    .busy        (busy),
    .checkDone   (check_done),
    .collision   (collision),
    .tickOverrun (tick_overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Segment RAM model with one cycle of read latency.
  always @(posedge clock) begin
    seg_x <= ram_x[seg_addr];
    seg_y <= ram_y[seg_addr];
  end

  typedef struct {
    string name;
    int    hx;
    int    hy;
    int    len;
    int    hit_idx;
    int    exp_done;
    int    exp_coll;
    int    exp_max;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    move_tick = 1'b0;
    step();
    reset      = 1'b1;
    coll_model = 0;
  endtask

  task automatic fill_bg();
    for (int i = 0; i < 64; i++) begin
      ram_x[i] = 6'd60;
      ram_y[i] = 6'(i % 24);
    end
  endtask

  // Starts a move in the current cycle and returns in the cycle checkDone is seen.
  task automatic run_txn(input string name, input int hx, input int hy, input int len,
                         input int inj_cyc, input int exp_done, input int exp_coll,
                         input int exp_max, input int exp_ovr);
    int cyc, done_at, max_addr, busy_bad, addr_at_done, busy_at_done, coll_at_done, ovr_at_done;
    addr_log.delete();
    head_x       = 6'(hx);
    head_y       = 6'(hy);
    snake_length = 7'(len);
    move_tick    = 1'b1;
    step();
    move_tick    = 1'b0;
    cyc          = 1;
    done_at      = -1;
    max_addr     = 0;
    busy_bad     = 0;
    addr_at_done = -1;
    busy_at_done = -1;
    coll_at_done = -1;
    ovr_at_done  = -1;
    while (cyc < 200) begin
      if (cyc == inj_cyc) begin
        move_tick = 1'b1;
        head_x    = 6'd20;
        head_y    = 6'd20;
      end
      if (check_done === 1'b1) begin
        done_at      = cyc;
        addr_at_done = int'(seg_addr);
        busy_at_done = int'(busy);
        coll_at_done = int'(collision);
        ovr_at_done  = int'(tick_overrun);
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      addr_log.push_back(int'(seg_addr));
      if (int'(seg_addr) > max_addr) max_addr = int'(seg_addr);
      step();
      move_tick = 1'b0;
      cyc++;
    end
    move_tick = 1'b0;
    chk({name, "_done_cycle"}, done_at, exp_done);
    chk({name, "_collision"}, coll_at_done, exp_coll);
    chk({name, "_busy_during"}, busy_bad, 0);
    chk({name, "_busy_at_done"}, busy_at_done, 0);
    chk({name, "_addr_at_done"}, addr_at_done, 0);
    chk({name, "_max_addr"}, max_addr, exp_max);
    chk({name, "_overrun"}, ovr_at_done, exp_ovr);
    $display("txn %s: head=(%0d,%0d) len=%0d done_cycle=%0d collision=%0d max_addr=%0d",
             name, hx, hy, len, done_at, coll_at_done, max_addr);
  endtask

  initial begin
    int hx, hy, len, l_eff, e_done, e_hit, e_max, found;

    vecs[0]  = '{"wall_x",      32,  5,   4, -1,  2, 1,  0};
    vecs[1]  = '{"wall_y",       5, 24,   4, -1,  2, 1,  0};
    vecs[2]  = '{"wall_x63",    63,  0,   8, -1,  2, 1,  0};
    vecs[3]  = '{"corner_ok",   31, 23,   4, -1,  6, 0,  3};
    vecs[4]  = '{"len1",         0,  0,   1, -1,  2, 0,  0};
    vecs[5]  = '{"len0",         0,  0,   0, -1,  2, 0,  0};
    vecs[6]  = '{"len2_clean",   7,  7,   2, -1,  4, 0,  1};
    vecs[7]  = '{"len2_hit",     7,  7,   2,  1,  4, 1,  1};
    vecs[8]  = '{"self_hit2",   10, 10,   8,  2,  5, 1,  3};
    vecs[9]  = '{"self_hit7",   10, 10,   8,  7, 10, 1,  7};
    vecs[10] = '{"len_clamp",    1,  1, 100, -1, 66, 0, 63};
    vecs[11] = '{"hit_last63",   2,  3,  64, 63, 66, 1, 63};
    vecs[12] = '{"head_idx0",    9,  9,   4,  0,  6, 0,  3};
    vecs[13] = '{"hit_past_len", 9,  9,   4,  5,  6, 0,  3};

    reset        = 1'b1;
    move_tick    = 1'b0;
    head_x       = '0;
    head_y       = '0;
    snake_length = '0;
    fill_bg();
    #3 reset = 1'b0;
    #1;
    chk("reset_seg_addr", int'(seg_addr), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_check_done", int'(check_done), 0);
    chk("reset_collision", int'(collision), 0);
    chk("reset_overrun", int'(tick_overrun), 0);
    step();
    reset = 1'b1;

    for (int v = 0; v < 14; v++) begin
      do_reset();
      fill_bg();
      if (vecs[v].hit_idx >= 0) begin
        ram_x[vecs[v].hit_idx] = 6'(vecs[v].hx);
        ram_y[vecs[v].hit_idx] = 6'(vecs[v].hy);
      end
      run_txn(vecs[v].name, vecs[v].hx, vecs[v].hy, vecs[v].len, 0,
              vecs[v].exp_done, vecs[v].exp_coll, vecs[v].exp_max, 0);
    end

    // Clean move with explicit body and address sequence.
    do_reset();
    fill_bg();
    ram_x[1] = 6'd3; ram_y[1] = 6'd5;
    ram_x[2] = 6'd2; ram_y[2] = 6'd5;
    ram_x[3] = 6'd1; ram_y[3] = 6'd5;
    run_txn("clean_move", 4, 5, 4, 0, 6, 0, 3, 0);
    chk("clean_addr_c2", addr_log.size() > 1 ? addr_log[1] : -1, 1);
    chk("clean_addr_c3", addr_log.size() > 2 ? addr_log[2] : -1, 2);
    chk("clean_addr_c4", addr_log.size() > 3 ? addr_log[3] : -1, 3);

    // Second tick mid-check aims at a body segment; latched head must win.
    do_reset();
    fill_bg();
    ram_x[4] = 6'd20; ram_y[4] = 6'd20;
    run_txn("overrun", 4, 5, 8, 3, 10, 0, 7, 1);

    // Back-to-back moves: each new tick lands in the previous checkDone cycle.
    do_reset();
    fill_bg();
    run_txn("b2b_short", 0, 0, 1, 0, 2, 0, 0, 0);
    run_txn("b2b_wall", 40, 0, 3, 0, 2, 1, 0, 0);
    run_txn("b2b_sticky", 4, 5, 3, 0, 5, 1, 2, 0);

    // Asynchronous reset in the middle of a scan.
    head_x = 6'd4; head_y = 6'd5; snake_length = 7'd8;
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
    step(); step(); step();
    chk("midscan_busy_c4", int'(busy), 1);
    chk("midscan_addr_c4", int'(seg_addr), 3);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_seg_addr", int'(seg_addr), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_check_done", int'(check_done), 0);
    chk("async_rst_collision", int'(collision), 0);
    chk("async_rst_overrun", int'(tick_overrun), 0);
    $display("txn async_reset: outputs cleared mid-scan");
    @(posedge clock);
    #1;
    reset      = 1'b1;
    coll_model = 0;
    run_txn("after_reset", 4, 5, 4, 0, 6, 0, 3, 0);

    // Random moves against the rule-level model; collision accumulates.
    do_reset();
    for (int t = 0; t < 40; t++) begin
      if (t % 10 == 9) do_reset();
      for (int i = 0; i < 64; i++) begin
        ram_x[i] = 6'($urandom_range(0, 5));
        ram_y[i] = 6'($urandom_range(0, 3));
      end
      hx  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(32, 40)) : int'($urandom_range(0, 5));
      hy  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 30)) : int'($urandom_range(0, 3));
      len = int'($urandom_range(0, 70));
      l_eff = (len == 0) ? 1 : ((len > 64) ? 64 : len);
      if (hx >= 32 || hy >= 24) begin
        e_done = 2; e_hit = 1; e_max = 0;
      end else if (l_eff <= 1) begin
        e_done = 2; e_hit = 0; e_max = 0;
      end else begin
        found = -1;
        for (int i = 1; i < l_eff; i++) begin
          if (found < 0 && int'(ram_x[i]) == hx && int'(ram_y[i]) == hy) found = i;
        end
        if (found > 0) begin
          e_done = found + 3;
          e_hit  = 1;
          e_max  = (found + 1 < l_eff - 1) ? found + 1 : l_eff - 1;
        end else begin
          e_done = l_eff + 2;
          e_hit  = 0;
          e_max  = l_eff - 1;
        end
      end
      coll_model = coll_model | e_hit;
      run_txn($sformatf("rand%0d", t), hx, hy, len, 0, e_done, coll_model, e_max, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
